// File: rtl/ex_pkg.sv
// Shared encodings for the execute stage: ALU select codes, branch funct3 codes
// and the multiplier sequencer state type.
package ex_pkg;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_AND   = 4'd2,
        ALU_OR    = 4'd3,
        ALU_XOR   = 4'd4,
        ALU_SLL   = 4'd5,
        ALU_SRL   = 4'd6,
        ALU_SRA   = 4'd7,
        ALU_SLT   = 4'd8,
        ALU_SLTU  = 4'd9,
        ALU_MUL   = 4'd10,
        ALU_MULH  = 4'd11,
        ALU_MULHU = 4'd12,
        ALU_PASSB = 4'd13
    } alu_op_e;

    typedef enum logic [2:0] {
        F3_BEQ  = 3'b000,
        F3_BNE  = 3'b001,
        F3_BLT  = 3'b100,
        F3_BGE  = 3'b101,
        F3_BLTU = 3'b110,
        F3_BGEU = 3'b111
    } br_funct3_e;

    typedef enum logic [1:0] {
        MUL_IDLE = 2'd0,
        MUL_BUSY = 2'd1,
        MUL_DONE = 2'd2
    } mul_state_e;

    localparam logic [4:0] MUL_LAST_STEP = 5'd31;

endpackage

// File: rtl/mul_unit.sv
// Sequential 32x32 multiplier: radix-2 shift-add over 32 BUSY cycles into a
// 64-bit accumulator; signed MULH is done on magnitudes with a final negate.
//
// state    | meaning
// MUL_IDLE | waiting for start
// MUL_BUSY | one shift-add step per cycle, step_cnt counts down to 0
// MUL_DONE | product valid on result for one cycle
module mul_unit
    import ex_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] result
);
    mul_state_e  state_q, state_d;
    logic [4:0]  step_cnt;
    logic [63:0] acc;
    logic [63:0] mcand;
    logic [31:0] mplier;
    logic        neg_q;
    logic [3:0]  op_q;
    logic        op_signed;
    logic [31:0] mag_a, mag_b;
    logic [63:0] product;

    assign op_signed = (op == ALU_MULH);
    assign mag_a     = (op_signed && a[31]) ? (32'd0 - a) : a;
    assign mag_b     = (op_signed && b[31]) ? (32'd0 - b) : b;

    always_ff @(posedge clk) begin
        if (reset) state_q <= MUL_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            MUL_IDLE: if (start) state_d = MUL_BUSY;
            MUL_BUSY: if (step_cnt == 5'd0) state_d = MUL_DONE;
            MUL_DONE: state_d = MUL_IDLE;
            default:  state_d = MUL_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            step_cnt <= 5'd0;
            acc      <= 64'd0;
            mcand    <= 64'd0;
            mplier   <= 32'd0;
            neg_q    <= 1'b0;
            op_q     <= 4'd0;
        end else if (state_q == MUL_IDLE && start) begin
            step_cnt <= MUL_LAST_STEP;
            acc      <= 64'd0;
            mcand    <= {32'd0, mag_a};
            mplier   <= mag_b;
            neg_q    <= op_signed && (a[31] ^ b[31]);
            op_q     <= op;
        end else if (state_q == MUL_BUSY) begin
            if (mplier[0]) acc <= acc + mcand;
            mcand    <= mcand << 1;
            mplier   <= mplier >> 1;
            step_cnt <= step_cnt - 5'd1;
        end
    end

    assign product = neg_q ? (64'd0 - acc) : acc;
    assign busy    = (state_q == MUL_BUSY);
    assign done    = (state_q == MUL_DONE);

    always_comb begin
        result = 32'd0;
        case (op_q)
            ALU_MUL:             result = product[31:0];
            ALU_MULH, ALU_MULHU: result = product[63:32];
            default:             result = 32'd0;
        endcase
    end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: inline ALU and branch compare, jump/branch redirect, and the
// EX/MEM pipeline register; multiplies stall the front end via mul_unit.
module ex_stage
    import ex_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_read_n,
    input  logic        mem_write_n,
    input  logic        mem_to_reg_n,
    input  logic        jumpl_n,
    input  logic        branch_n,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [31:0] PC_n2,
    input  logic [31:0] PC_in2,
    input  logic [31:0] rs2data,
    input  logic [31:0] instr_n,
    input  logic [3:0]  alu_select,
    output logic        stall,
    output logic        redirect,
    output logic [31:0] redirect_pc,
    output logic        mem_read_m,
    output logic        mem_write_m,
    output logic        mem_to_reg_m,
    output logic        reg_write_m,
    output logic [31:0] result_m,
    output logic [31:0] store_data_m,
    output logic [4:0]  rd_m
);
    logic        bubble;
    logic        mul_op;
    logic        mul_start, mul_busy, mul_done;
    logic [31:0] mul_result;
    logic [31:0] alu_y;
    logic        br_taken;
    logic        take;
    logic [31:0] b_imm;
    logic [31:0] target;
    logic        unused_instr;

    assign bubble       = (instr_n == 32'd0);
    assign mul_op       = (alu_select == ALU_MUL) || (alu_select == ALU_MULH) ||
                          (alu_select == ALU_MULHU);
    assign mul_start    = mul_op && !bubble;
    // Issue cycle stalls only while the unit is idle; DONE releases the front end.
    assign stall        = mul_busy || (mul_start && !mul_done);
    assign unused_instr = ^{instr_n[24:15], instr_n[6:0]};

    mul_unit u_mul (
        .clk    (clk),
        .reset  (reset),
        .start  (mul_start),
        .op     (alu_select),
        .a      (A),
        .b      (B),
        .busy   (mul_busy),
        .done   (mul_done),
        .result (mul_result)
    );

    always_comb begin
        alu_y = 32'd0;
        case (alu_select)
            ALU_ADD:   alu_y = A + B;
            ALU_SUB:   alu_y = A - B;
            ALU_AND:   alu_y = A & B;
            ALU_OR:    alu_y = A | B;
            ALU_XOR:   alu_y = A ^ B;
            ALU_SLL:   alu_y = A << B[4:0];
            ALU_SRL:   alu_y = A >> B[4:0];
            ALU_SRA:   alu_y = $signed(A) >>> B[4:0];
            ALU_SLT:   alu_y = {31'd0, ($signed(A) < $signed(B))};
            ALU_SLTU:  alu_y = {31'd0, (A < B)};
            ALU_PASSB: alu_y = B;
            default:   alu_y = 32'd0;
        endcase
    end

    always_comb begin
        br_taken = 1'b0;
        case (instr_n[14:12])
            F3_BEQ:  br_taken = (A == rs2data);
            F3_BNE:  br_taken = (A != rs2data);
            F3_BLT:  br_taken = ($signed(A) < $signed(rs2data));
            F3_BGE:  br_taken = ($signed(A) >= $signed(rs2data));
            F3_BLTU: br_taken = (A < rs2data);
            F3_BGEU: br_taken = (A >= rs2data);
            default: br_taken = 1'b0;
        endcase
    end

    assign b_imm  = {{20{instr_n[31]}}, instr_n[7], instr_n[30:25], instr_n[11:8], 1'b0};
    assign target = jumpl_n ? ((A + B) & ~32'h1) : (PC_in2 + b_imm);
    assign take   = !bubble && !stall && !mul_op && (jumpl_n || (branch_n && br_taken));

    always_ff @(posedge clk) begin
        if (reset) begin
            redirect     <= 1'b0;
            redirect_pc  <= 32'd0;
            mem_read_m   <= 1'b0;
            mem_write_m  <= 1'b0;
            mem_to_reg_m <= 1'b0;
            reg_write_m  <= 1'b0;
            result_m     <= 32'd0;
            store_data_m <= 32'd0;
            rd_m         <= 5'd0;
        end else begin
            redirect <= take;
            if (take) redirect_pc <= target;
            if (bubble || stall) begin
                mem_read_m   <= 1'b0;
                mem_write_m  <= 1'b0;
                mem_to_reg_m <= 1'b0;
                reg_write_m  <= 1'b0;
                result_m     <= 32'd0;
                store_data_m <= 32'd0;
                rd_m         <= 5'd0;
            end else begin
                mem_read_m   <= mem_read_n;
                mem_write_m  <= mem_write_n;
                mem_to_reg_m <= mem_to_reg_n;
                reg_write_m  <= !mem_write_n && !branch_n;
                result_m     <= jumpl_n ? PC_n2 : (mul_op ? mul_result : alu_y);
                store_data_m <= rs2data;
                rd_m         <= instr_n[11:7];
            end
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: stimulus queues expectations tagged with the
// cycle they fall due; a negedge monitor pops and compares them.
module tb_ex_stage;
    import ex_pkg::*;

    logic        clk, reset;
    logic        mem_read_n, mem_write_n, mem_to_reg_n, jumpl_n, branch_n;
    logic [31:0] A, B, PC_n2, PC_in2, rs2data, instr_n;
    logic [3:0]  alu_select;
    logic        stall, redirect;
    logic [31:0] redirect_pc;
    logic        mem_read_m, mem_write_m, mem_to_reg_m, reg_write_m;
    logic [31:0] result_m, store_data_m;
    logic [4:0]  rd_m;

    ex_stage dut (
        .clk(clk), .reset(reset),
        .mem_read_n(mem_read_n), .mem_write_n(mem_write_n), .mem_to_reg_n(mem_to_reg_n),
        .jumpl_n(jumpl_n), .branch_n(branch_n),
        .A(A), .B(B), .PC_n2(PC_n2), .PC_in2(PC_in2), .rs2data(rs2data), .instr_n(instr_n),
        .alu_select(alu_select),
        .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .mem_read_m(mem_read_m), .mem_write_m(mem_write_m), .mem_to_reg_m(mem_to_reg_m),
        .reg_write_m(reg_write_m), .result_m(result_m), .store_data_m(store_data_m), .rd_m(rd_m)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        string       name;
        bit          chk_stall;
        bit          chk_out;
        bit          chk_data;
        logic        stall;
        logic [3:0]  ctrl;
        logic        redirect;
        logic [31:0] rpc;
        logic [31:0] result;
        logic [4:0]  rd;
        logic [31:0] sdata;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          failures = 0;
    logic [31:0] rpc_model = 32'd0;

    typedef struct {
        logic [3:0]  sel;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] y;
        string       name;
    } alu_vec_t;
    alu_vec_t alu_tab[$];

    function automatic void add_vec(input logic [3:0] sel, input logic [31:0] a_v,
                                    input logic [31:0] b_v, input logic [31:0] y_v,
                                    input string n);
        alu_vec_t v;
        v.sel = sel; v.a = a_v; v.b = b_v; v.y = y_v; v.name = n;
        alu_tab.push_back(v);
    endfunction

    function automatic void push(input int c, input string n, input bit cs, input bit co,
                                 input bit cd, input logic s, input logic [3:0] ctrl,
                                 input logic rdr, input logic [31:0] res,
                                 input logic [4:0] rd, input logic [31:0] sd);
        exp_t e;
        e.cyc = c; e.name = n; e.chk_stall = cs; e.chk_out = co; e.chk_data = cd;
        e.stall = s; e.ctrl = ctrl; e.redirect = rdr; e.rpc = rpc_model;
        e.result = res; e.rd = rd; e.sdata = sd;
        sb.push_back(e);
    endfunction

    function automatic void exp_stall(input int c, input string n, input logic s);
        push(c, n, 1'b1, 1'b0, 1'b0, s, 4'd0, 1'b0, 32'd0, 5'd0, 32'd0);
    endfunction

    function automatic void exp_ctrl(input int c, input string n, input logic [3:0] ctrl,
                                     input logic rdr);
        push(c, n, 1'b0, 1'b1, 1'b0, 1'b0, ctrl, rdr, 32'd0, 5'd0, 32'd0);
    endfunction

    function automatic void exp_all(input int c, input string n, input logic [3:0] ctrl,
                                    input logic rdr, input logic [31:0] res,
                                    input logic [4:0] rd, input logic [31:0] sd);
        push(c, n, 1'b0, 1'b1, 1'b1, 1'b0, ctrl, rdr, res, rd, sd);
    endfunction

    function automatic void check_one(input exp_t e);
        bit         bad;
        logic [3:0] ctrl_act;
        ctrl_act = {mem_read_m, mem_write_m, mem_to_reg_m, reg_write_m};
        bad = 1'b0;
        if (e.chk_stall && stall !== e.stall) bad = 1'b1;
        if (e.chk_out && (ctrl_act !== e.ctrl || redirect !== e.redirect ||
                          redirect_pc !== e.rpc)) bad = 1'b1;
        if (e.chk_data && (result_m !== e.result || rd_m !== e.rd ||
                           store_data_m !== e.sdata)) bad = 1'b1;
        checks++;
        if (bad) begin
            failures++;
            $display("FAIL %s cyc=%0d got: stall=%b ctrl=%b redirect=%b rpc=%h result=%h rd=%0d sdata=%h | expected: stall=%b ctrl=%b redirect=%b rpc=%h result=%h rd=%0d sdata=%h",
                     e.name, cyc, stall, ctrl_act, redirect, redirect_pc, result_m, rd_m,
                     store_data_m, e.stall, e.ctrl, e.redirect, e.rpc, e.result, e.rd, e.sdata);
        end
    endfunction

    always @(negedge clk) begin : monitor
        int idx;
        idx = 0;
        while (idx < sb.size()) begin
            if (sb[idx].cyc == cyc) begin
                check_one(sb[idx]);
                sb.delete(idx);
            end else if (sb[idx].cyc < cyc) begin
                checks++;
                failures++;
                $display("FAIL %s expired: due cyc=%0d, now cyc=%0d", sb[idx].name, sb[idx].cyc, cyc);
                sb.delete(idx);
            end else begin
                idx++;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        mem_read_n = 1'b0; mem_write_n = 1'b0; mem_to_reg_n = 1'b0;
        jumpl_n = 1'b0; branch_n = 1'b0;
        A = 32'd0; B = 32'd0; PC_n2 = 32'd0; PC_in2 = 32'd0; rs2data = 32'd0;
        instr_n = 32'd0; alu_select = 4'd0;
    endtask

    // ctl = {mem_read, mem_write, mem_to_reg, jumpl, branch}
    task automatic set_op(input logic [3:0] sel, input logic [31:0] a_v, input logic [31:0] b_v,
                          input logic [31:0] rs2_v, input logic [31:0] pc_v,
                          input logic [31:0] pc4_v, input logic [31:0] ins_v,
                          input logic [4:0] ctl);
        alu_select = sel; A = a_v; B = b_v; rs2data = rs2_v; PC_in2 = pc_v; PC_n2 = pc4_v;
        instr_n = ins_v;
        {mem_read_n, mem_write_n, mem_to_reg_n, jumpl_n, branch_n} = ctl;
    endtask

    task automatic do_mul(input logic [3:0] sel, input logic [31:0] a_v, input logic [31:0] b_v,
                          input logic [31:0] rs2_v, input logic [4:0] rd,
                          input logic [31:0] y, input string n, input bit every_stall);
        int k;
        step();
        set_op(sel, a_v, b_v, rs2_v, 32'd0, 32'd0, 32'h0200_0033 | (32'(rd) << 7), 5'b00000);
        k = cyc;
        if (every_stall) begin
            for (int i = 0; i <= 32; i++) exp_stall(k + i, {n, "_stall"}, 1'b1);
        end else begin
            exp_stall(k, {n, "_stall_issue"}, 1'b1);
            exp_stall(k + 32, {n, "_stall_last_busy"}, 1'b1);
        end
        exp_stall(k + 33, {n, "_done_nostall"}, 1'b0);
        exp_ctrl(k + 1, {n, "_bubble_during_stall"}, 4'b0000, 1'b0);
        exp_all(k + 34, n, 4'b0001, 1'b0, y, rd, rs2_v);
        repeat (33) step();
    endtask

    initial begin : stimulus
        int          k;
        logic [4:0]  rd;
        reset = 1'b1;
        set_idle();
        step();
        step();
        push(cyc, "reset_state", 1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 32'd0, 5'd0, 32'd0);
        step();
        reset = 1'b0;

        // ADD 7 + (-3)
        step();
        set_op(ALU_ADD, 32'd7, 32'hFFFF_FFFD, 32'h55, 32'd0, 32'd0, 32'h0000_01B3, 5'b00000);
        exp_stall(cyc, "add_nostall", 1'b0);
        exp_all(cyc + 1, "add_7_m3", 4'b0001, 1'b0, 32'd4, 5'd3, 32'h55);

        add_vec(ALU_SUB,   32'd5,         32'd7,         32'hFFFF_FFFE, "sub");
        add_vec(ALU_AND,   32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, "and");
        add_vec(ALU_OR,    32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0, "or");
        add_vec(ALU_XOR,   32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, "xor");
        add_vec(ALU_SLL,   32'd1,         32'd33,        32'd2,         "sll_b4_0");
        add_vec(ALU_SRL,   32'h8000_0000, 32'd4,         32'h0800_0000, "srl");
        add_vec(ALU_SRA,   32'h8000_0000, 32'd4,         32'hF800_0000, "sra");
        add_vec(ALU_SLT,   32'hFFFF_FFFF, 32'd1,         32'd1,         "slt");
        add_vec(ALU_SLTU,  32'hFFFF_FFFF, 32'd1,         32'd0,         "sltu");
        add_vec(ALU_PASSB, 32'd0,         32'h1234,      32'h1234,      "passb");
        add_vec(4'd14,     32'd5,         32'd6,         32'd0,         "sel14");
        add_vec(4'd15,     32'd5,         32'd6,         32'd0,         "sel15");
        add_vec(ALU_ADD,   32'hFFFF_FFFF, 32'd1,         32'd0,         "add_wrap");
        foreach (alu_tab[i]) begin
            rd = 5'(i + 4);
            step();
            set_op(alu_tab[i].sel, alu_tab[i].a, alu_tab[i].b, 32'd0, 32'd0, 32'd0,
                   32'h33 | (32'(rd) << 7), 5'b00000);
            exp_all(cyc + 1, alu_tab[i].name, 4'b0001, 1'b0, alu_tab[i].y, rd, 32'd0);
        end

        // Branches
        step();
        set_op(ALU_SUB, 32'd5, 32'd0, 32'd5, 32'h100, 32'h104, 32'h0000_0863, 5'b00001);
        rpc_model = 32'h110;
        exp_ctrl(cyc + 1, "beq_taken", 4'b0000, 1'b1);
        step();
        set_idle();
        exp_ctrl(cyc + 1, "redirect_pulse_ends", 4'b0000, 1'b0);
        step();
        set_op(ALU_SUB, 32'd5, 32'd0, 32'd6, 32'h100, 32'h104, 32'h0000_0863, 5'b00001);
        exp_ctrl(cyc + 1, "beq_not_taken", 4'b0000, 1'b0);
        step();
        set_op(ALU_SUB, 32'hFFFF_FFFF, 32'd0, 32'd1, 32'h200, 32'h204, 32'h0000_4863, 5'b00001);
        rpc_model = 32'h210;
        exp_ctrl(cyc + 1, "blt_taken", 4'b0000, 1'b1);
        step();
        set_op(ALU_SUB, 32'hFFFF_FFFF, 32'd0, 32'd1, 32'h200, 32'h204, 32'h0000_6863, 5'b00001);
        exp_ctrl(cyc + 1, "bltu_not_taken", 4'b0000, 1'b0);
        step();
        set_op(ALU_SUB, 32'd9, 32'd0, 32'd9, 32'h200, 32'h204, 32'h0000_2863, 5'b00001);
        exp_ctrl(cyc + 1, "funct3_010_not_taken", 4'b0000, 1'b0);
        step();
        set_op(ALU_SUB, 32'd3, 32'd0, 32'hFFFF_FFFE, 32'h300, 32'h304, 32'hFE00_5EE3, 5'b00001);
        rpc_model = 32'h2FC;
        exp_ctrl(cyc + 1, "bge_neg_imm", 4'b0000, 1'b1);

        // JALR clears bit 0 of the target and links PC+4
        step();
        set_op(ALU_ADD, 32'h203, 32'd0, 32'd0, 32'h40, 32'h44, 32'h0000_00E7, 5'b00010);
        rpc_model = 32'h202;
        exp_all(cyc + 1, "jalr", 4'b0001, 1'b1, 32'h44, 5'd1, 32'd0);

        // Store, load, then a bubble with every control set
        step();
        set_op(ALU_ADD, 32'h1000, 32'd8, 32'hCAFE_BABE, 32'd0, 32'd0, 32'h0000_2023, 5'b01000);
        exp_all(cyc + 1, "store", 4'b0100, 1'b0, 32'h1008, 5'd0, 32'hCAFE_BABE);
        step();
        set_op(ALU_ADD, 32'h2000, 32'd4, 32'd0, 32'd0, 32'd0, 32'h0000_2283, 5'b10100);
        exp_all(cyc + 1, "load", 4'b1011, 1'b0, 32'h2004, 5'd5, 32'd0);
        step();
        set_op(ALU_ADD, 32'd1, 32'd2, 32'd3, 32'h500, 32'h504, 32'd0, 5'b11111);
        exp_stall(cyc, "bubble_nostall", 1'b0);
        exp_ctrl(cyc + 1, "bubble_store", 4'b0000, 1'b0);

        // Multiplies
        do_mul(ALU_MULH,  32'hFFFF_FFFF, 32'd2, 32'h77, 5'd7, 32'hFFFF_FFFF, "mulh", 1'b1);
        do_mul(ALU_MULHU, 32'hFFFF_FFFF, 32'd2, 32'h11, 5'd8, 32'h0000_0001, "mulhu", 1'b0);
        do_mul(ALU_MUL,   32'hFFFF_FFFF, 32'd2, 32'h22, 5'd9, 32'hFFFF_FFFE, "mul", 1'b0);

        // Reset in BUSY cycle 10 aborts the multiply
        step();
        set_op(ALU_MUL, 32'd3, 32'd5, 32'd0, 32'd0, 32'd0, 32'h0200_0433, 5'b00000);
        k = cyc;
        exp_stall(k, "abort_issue_stall", 1'b1);
        repeat (10) step();
        exp_stall(cyc, "abort_busy10_stall", 1'b1);
        reset = 1'b1;
        set_idle();
        step();
        reset = 1'b0;
        rpc_model = 32'd0;
        push(cyc, "abort_reset_outputs", 1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 32'd0, 5'd0, 32'd0);
        step();
        set_op(ALU_ADD, 32'd10, 32'd20, 32'h99, 32'd0, 32'd0, 32'h0000_04B3, 5'b00000);
        exp_stall(cyc, "add_after_abort_nostall", 1'b0);
        exp_all(cyc + 1, "add_after_abort", 4'b0001, 1'b0, 32'd30, 5'd9, 32'h99);
        step();
        set_idle();
        while (cyc < k + 40) begin
            step();
            exp_stall(cyc, "abort_no_stall", 1'b0);
            exp_ctrl(cyc, "abort_no_result", 4'b0000, 1'b0);
        end

        step();
        step();
        while (sb.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL %s never compared (due cyc=%0d)", sb[0].name, sb[0].cyc);
            void'(sb.pop_front());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog timeout at cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

endmodule
